// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, waits out the instruction-memory read latency and
// hands the captured instruction fields to decode through a valid/ready handshake.
module fetch_controller #(
  parameter int unsigned  SIZE_WORD   = 2,
  parameter int unsigned  MEM_LATENCY = 1,
  parameter logic [5:0]   HALT_OP     = 6'h3F,
  localparam int unsigned AW          = $clog2(SIZE_WORD * 4)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_addr,
  output logic [AW-1:0] imem_addr,
  input  logic [5:0]    imem_op,
  input  logic [5:0]    imem_func,
  input  logic [4:0]    imem_rs,
  input  logic [4:0]    imem_rt,
  input  logic [4:0]    imem_rd,
  input  logic [4:0]    imem_shamt,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [5:0]    op,
  output logic [5:0]    func,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [4:0]    shamt,
  output logic [AW-1:0] instr_pc,
  output logic          halted,
  output logic [15:0]   fetch_count
);

  localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]    r_state, w_state_d;
  logic [AW-1:0] r_pc, w_pc_d;
  logic [CW-1:0] r_cnt, w_cnt_d;
  logic          r_valid, w_valid_d;
  logic          r_halted, w_halted_d;
  logic          w_capture;
  logic          w_accept;
  logic [AW-1:0] w_redirect_pc;

  logic [5:0]    r_op, r_func;
  logic [4:0]    r_rs, r_rt, r_rd, r_shamt;
  logic [AW-1:0] r_instr_pc;
  logic [15:0]   r_fetch_count;

  // Fetches are word aligned, so the byte offset of a redirect target is dropped.
  assign w_redirect_pc = redirect_addr & ~AW'(3);

  always_comb begin
    w_state_d  = r_state;
    w_pc_d     = r_pc;
    w_cnt_d    = r_cnt;
    w_valid_d  = r_valid;
    w_halted_d = r_halted;
    w_capture  = 1'b0;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pc_d    = '0;
          w_state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (redirect_valid) begin
          w_pc_d = w_redirect_pc;
        end else begin
          w_cnt_d   = CW'(MEM_LATENCY - 1);
          w_state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_d    = w_redirect_pc;
          w_state_d = S_ISSUE;
        end else if (r_cnt == '0) begin
          w_capture = 1'b1;
          w_valid_d = 1'b1;
          w_state_d = S_HOLD;
        end else begin
          w_cnt_d = r_cnt - CW'(1);
        end
      end
      S_HOLD: begin
        // A redirect squashes the held instruction even if decode accepts it this cycle.
        if (redirect_valid) begin
          w_valid_d = 1'b0;
          w_pc_d    = w_redirect_pc;
          w_state_d = S_ISSUE;
        end else if (instr_ready) begin
          w_valid_d = 1'b0;
          w_accept  = 1'b1;
          if (r_op == HALT_OP) begin
            w_halted_d = 1'b1;
            w_state_d  = S_HALT;
          end else begin
            w_pc_d    = r_pc + AW'(4);
            w_state_d = S_ISSUE;
          end
        end
      end
      S_HALT: begin
        w_valid_d = 1'b0;
      end
      default: begin
        w_valid_d = 1'b0;
        w_state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_cnt         <= '0;
      r_valid       <= 1'b0;
      r_halted      <= 1'b0;
      r_op          <= '0;
      r_func        <= '0;
      r_rs          <= '0;
      r_rt          <= '0;
      r_rd          <= '0;
      r_shamt       <= '0;
      r_instr_pc    <= '0;
      r_fetch_count <= '0;
    end else begin
      r_state  <= w_state_d;
      r_pc     <= w_pc_d;
      r_cnt    <= w_cnt_d;
      r_valid  <= w_valid_d;
      r_halted <= w_halted_d;
      if (w_capture) begin
        r_op       <= imem_op;
        r_func     <= imem_func;
        r_rs       <= imem_rs;
        r_rt       <= imem_rt;
        r_rd       <= imem_rd;
        r_shamt    <= imem_shamt;
        r_instr_pc <= r_pc;
      end
      if (w_accept && (r_fetch_count != 16'hFFFF)) begin
        r_fetch_count <= r_fetch_count + 16'd1;
      end
    end
  end

  // The PC register doubles as the memory address, so it only moves on entry to ISSUE.
  assign imem_addr   = r_pc;
  assign instr_valid = r_valid;
  assign op          = r_op;
  assign func        = r_func;
  assign rs          = r_rs;
  assign rt          = r_rt;
  assign rd          = r_rd;
  assign shamt       = r_shamt;
  assign instr_pc    = r_instr_pc;
  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences instruction fetch from the byte-addressed instruction memory: owns the PC, drives the memory read address, waits the memory's fixed read latency, then captures the decoded fields (op/rs/rt/rd/shamt/func) and presents them to decode with a valid/ready handshake. Handles branch/jump redirects, halts on a HALT opcode, and counts accepted instructions. Sits between the instruction memory and the decode/control stage.

Parameters:
SIZE_WORD, 2, number of 32-bit words in instruction memory; address width AW = $clog2(SIZE_WORD*4)
MEM_LATENCY, 1, cycles (>=1) the memory needs after the address is stable before its field outputs are valid
HALT_OP, 6'h3F, opcode that stops fetching once accepted

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  leave IDLE and begin fetching at PC 0
redirect_valid  input  1  branch/jump taken this cycle
redirect_addr  input  AW  new fetch byte address
imem_addr  output  AW  read address to instruction memory
imem_op, imem_func  input  6  fields from instruction memory
imem_rs, imem_rt, imem_rd, imem_shamt  input  5  fields from instruction memory
instr_valid  output  1  captured instruction available
instr_ready  input  1  decode accepts instruction
op, func  output  6  captured fields
rs, rt, rd, shamt  output  5  captured fields
instr_pc  output  AW  byte address of captured instruction
halted  output  1  HALT_OP accepted, fetching stopped
fetch_count  output  16  instructions accepted by decode

Behaviour:
- Reset (async, rst_n=0): state IDLE; pc, imem_addr, instr_pc, all fields, fetch_count = 0; instr_valid=0; halted=0. Reset mid-fetch discards everything.
- imem_addr is a register equal to pc; it changes only on entry to ISSUE and is stable through ISSUE and WAIT.
- States: IDLE, ISSUE, WAIT, HOLD, HALT.
- IDLE: start=1 -> pc=0, ISSUE. redirect ignored.
- ISSUE (exactly 1 cycle): load wait counter = MEM_LATENCY-1 -> WAIT.
- WAIT: counter decrements each cycle; on the cycle counter==0, capture imem_* into field outputs, instr_pc=pc, set instr_valid -> HOLD. Latency: ISSUE entry to instr_valid high = MEM_LATENCY+1 cycles.
- HOLD: outputs held stable while instr_ready=0. On instr_ready=1: instr_valid=0, fetch_count+1 (saturates at 16'hFFFF); if op==HALT_OP -> HALT, halted=1; else pc=pc+4 (mod 2^AW, wraps from last word to 0) -> ISSUE.
- HALT: terminal until reset; instr_valid=0; start and redirect ignored.
- Redirect (ISSUE, WAIT or HOLD): highest priority. pc = {redirect_addr[AW-1:2],2'b00} (low bits forced 0), instr_valid=0, in-flight/held instruction discarded and not counted, -> ISSUE. Redirect and instr_ready in same HOLD cycle: redirect wins, no count.
- instr_valid never drops without instr_ready or redirect.
- Back-to-back throughput with instr_ready tied high: one instruction per MEM_LATENCY+2 cycles.

Test Plan:
- Reset then start, MEM_LATENCY=2, instr_ready=1, memory word0 op=6'h08 -> imem_addr=0, instr_valid rises 3 cycles after ISSUE, op=6'h08, instr_pc=0, fetch_count=1, next imem_addr=4.
- SIZE_WORD=2, continuous fetch, no HALT -> imem_addr sequence 0,4,0,4 (wrap), fetch_count increments per acceptance.
- instr_ready held 0 for 5 cycles in HOLD -> fields, instr_pc, instr_valid stable; fetch_count unchanged; acceptance on 6th cycle counts once.
- redirect_valid=1, redirect_addr=3'b111 during WAIT -> instr_valid stays 0, next ISSUE with imem_addr=3'b100; redirect with instr_ready=1 in HOLD -> fetch_count unchanged.
- Word at address 4 has op=6'h3F -> accepted, halted=1, no further imem_addr change; start/redirect afterwards have no effect.
- rst_n pulled low asynchronously mid-WAIT -> all outputs 0 immediately, state IDLE; fetch resumes only after start.
